// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: walks the frame in raster order (optionally bottom-up in memory), issues
// one-cycle-latency reads and streams pixels with x/y/sof/eol sideband through a 2-entry skid FIFO.
module fb_scanout_reader #(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 240,
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned FLIP_Y = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_fb_r_addr,
    output logic              o_fb_re,
    input  logic [PIX_W-1:0]  i_fb_r_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic [8:0]        o_pix_x,
    output logic [7:0]        o_pix_y,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_done
);
    localparam logic [8:0]        XLast    = 9'(H_RES - 1);
    localparam logic [7:0]        YLast    = 8'(V_RES - 1);
    localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] BaseInit = (FLIP_Y != 0) ? ADDR_W'((V_RES - 1) * H_RES) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       sof;
        logic       eol;
    } side_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        side_t            side;
    } entry_t;

    state_e            state_q, state_d;
    logic [8:0]        x_rd_q, x_rd_d;
    logic [7:0]        y_rd_q, y_rd_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    side_t             side_q, side_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              done_q, done_d;
    entry_t            fifo_q [2];

    logic   rd_en;
    logic   [1:0] occ;
    logic   out_valid;
    logic   xfer;
    logic   last_xfer;
    logic   push;
    logic   pop;
    entry_t in_entry;
    entry_t head;

    always_comb begin
        state_d    = state_q;
        x_rd_d     = x_rd_q;
        y_rd_d     = y_rd_q;
        row_base_d = row_base_q;
        side_d     = side_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;

        in_entry.data = i_fb_r_data;
        in_entry.side = side_q;

        // Pixels buffered plus the read whose data lands this cycle.
        occ       = count_q + {1'b0, inflight_q};
        out_valid = (count_q != 2'd0) || inflight_q;
        // With an empty FIFO the returning read data is presented directly.
        head      = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : in_entry;
        xfer      = out_valid && i_pix_ready;
        last_xfer = xfer && (head.side.x == XLast) && (head.side.y == YLast);

        push     = inflight_q && !((count_q == 2'd0) && xfer);
        pop      = xfer && (count_q != 2'd0);
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StRun;
                    x_rd_d     = '0;
                    y_rd_d     = '0;
                    row_base_d = BaseInit;
                end
            end
            StRun: begin
                rd_en = (occ < 2'd2) || ((occ == 2'd2) && xfer);
                if (rd_en) begin
                    side_d.x   = x_rd_q;
                    side_d.y   = y_rd_q;
                    side_d.sof = (x_rd_q == 9'd0) && (y_rd_q == 8'd0);
                    side_d.eol = (x_rd_q == XLast);
                    if (x_rd_q == XLast) begin
                        x_rd_d = '0;
                        y_rd_d = y_rd_q + 8'd1;
                        if (FLIP_Y != 0) begin
                            row_base_d = row_base_q - RowStep;
                        end else begin
                            row_base_d = row_base_q + RowStep;
                        end
                        if (y_rd_q == YLast) begin
                            state_d = StDrain;
                        end
                    end else begin
                        x_rd_d = x_rd_q + 9'd1;
                    end
                end
            end
            StDrain: begin
                if (last_xfer) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        inflight_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            x_rd_q     <= '0;
            y_rd_q     <= '0;
            row_base_q <= '0;
            side_q     <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_rd_q     <= x_rd_d;
            y_rd_q     <= y_rd_d;
            row_base_q <= row_base_d;
            side_q     <= side_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            done_q     <= done_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_entry;
        end
    end

    always_comb begin
        o_busy      = (state_q != StIdle);
        o_fb_re     = rd_en;
        o_fb_r_addr = (state_q == StRun) ? (row_base_q + ADDR_W'(x_rd_q)) : '0;
        o_pix_valid = out_valid;
        o_pix_data  = out_valid ? head.data     : '0;
        o_pix_x     = out_valid ? head.side.x   : '0;
        o_pix_y     = out_valid ? head.side.y   : '0;
        o_sof       = out_valid && head.side.sof;
        o_eol       = out_valid && head.side.eol;
        o_done      = done_q;
    end

endmodule
